// File: rtl/seq_multiplier8.sv
// Sequential shift-and-add multiplier: WIDTH steps per product, valid/ready on both sides.
// Define MUL_SIGNED_EN for two's-complement operands (final step subtracts the multiplicand).
module seq_multiplier8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]   hi;
  logic [WIDTH:0]     add_a, add_b, sum;
  logic               last_step;

  assign hi        = acc_q[2*WIDTH-1:WIDTH];
  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  // Adder stage: bit WIDTH of sum is the carry (unsigned) or the sign (signed).
`ifdef MUL_SIGNED_EN
  logic carry_in;

  always_comb begin
    add_a    = {hi[WIDTH-1], hi};
    add_b    = acc_q[0] ? {mcand_q[WIDTH-1], mcand_q} : '0;
    carry_in = 1'b0;
    // The multiplier's sign bit carries weight -2^(WIDTH-1), so the last step subtracts.
    if (last_step && acc_q[0]) begin
      add_b    = ~add_b;
      carry_in = 1'b1;
    end
    sum = add_a + add_b + {{WIDTH{1'b0}}, carry_in};
  end
`else
  always_comb begin
    add_a = {1'b0, hi};
    add_b = acc_q[0] ? {1'b0, mcand_q} : '0;
    sum   = add_a + add_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Dropping the LSB of {sum, lo} is the right shift; sum's top bit refills hi.
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StCalc);
    out_valid = (state_q == StDone);
    product   = acc_q;
  end

endmodule

// File: tb/tb_seq_multiplier8.sv
// Scoreboard bench for seq_multiplier8: stimulus pushes model results, a monitor pops and compares.
// Build with MUL_SIGNED_EN defined to check the signed variant.
module tb_seq_multiplier8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];

  seq_multiplier8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    int p;
`ifdef MUL_SIGNED_EN
    int sx = $signed(x);
    int sy = $signed(y);
`else
    int sx = int'(x);
    int sy = int'(y);
`endif
    p = sx * sy;
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", product);
      end else begin
        check("product", {16'h0, product}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, output int acc_edge);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1");
    end
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    exp_q.push_back(model(ta, tb));
    @(posedge clk);
    #1;
    acc_edge = cyc;
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
  endtask

  task automatic check_latency(input int acc_edge);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", cyc - acc_edge, 8);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  logic [7:0] ta_tbl[6] = '{8'hFF, 8'h00, 8'hFD, 8'h80, 8'h7F, 8'h01};
  logic [7:0] tb_tbl[6] = '{8'hFF, 8'hA5, 8'h05, 8'h80, 8'h80, 8'hFF};

  initial begin
    int acc1;
    int acc2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_product", product, 0);

    // 5 x 5 with exact busy/out_valid timing.
    issue(8'd5, 8'd5, acc1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("busy_window", busy, 1);
      check("early_out_valid", out_valid, 0);
    end
    @(negedge clk);
    check("done_out_valid", out_valid, 1);
    check("done_busy", busy, 0);
    check("done_latency", cyc - acc1, 8);
    drain();

    // Corner operands.
    for (int i = 0; i < 6; i++) begin
      issue(ta_tbl[i], tb_tbl[i], acc1);
      check_latency(acc1);
      drain();
    end

    // Backpressure: product must hold while the consumer stalls.
    out_ready = 1'b0;
    issue(8'($urandom), 8'($urandom), acc1);
    check_latency(acc1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_product", product, exp_q[0]);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Operand isolation: in_valid pulses during CALC must not disturb the result.
    issue(8'd200, 8'd3, acc1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a        = 8'($urandom);
      b        = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset during step 3 discards the operation.
    issue(8'd7, 8'd9, acc1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    issue(8'd7, 8'd9, acc1);
    check_latency(acc1);
    drain();

    // Back-to-back requests: one-cycle bubble after the output handshake.
    issue(8'($urandom), 8'($urandom), acc1);
    issue(8'($urandom), 8'($urandom), acc2);
    check("issue_interval", acc2 - acc1, 10);
    drain();

    // Random traffic with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      issue(8'($urandom), 8'($urandom), acc1);
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
